// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS-style control FSM: sequences fetch, decode, memory, ALU and
// jump phases, with a per-access memory wait timeout and sticky error flags.
module mc_control_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int ALU_CTRL_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [5:0]            op_i,
  input  logic [5:0]            funct_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic                  i_or_d_o,
  output logic                  ir_write_o,
  output logic                  pc_write_o,
  output logic [1:0]            pc_src_o,
  output logic                  alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  reg_write_o,
  output logic                  reg_dst_o,
  output logic                  mem_to_reg_o,
  output logic                  sign_o,
  output logic                  link_o,
  output logic                  illegal_o,
  output logic                  bus_err_o
);

  localparam int CW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(0);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(1);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(2);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL = ALU_CTRL_W'(3);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(6);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(7);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL = ALU_CTRL_W'(8);
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA = ALU_CTRL_W'(9);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
    S_IMMEX, S_IMMWB, S_BRANCH, S_JUMP, S_JREG, S_JLINK, S_ERROR
  } state_e;

  // Registered Moore outputs; fetch/branch/bne qualify the input-gated strobes.
  typedef struct packed {
    logic                  mem_req;
    logic                  mem_we;
    logic                  i_or_d;
    logic                  pc_write;
    logic                  fetch;
    logic                  branch;
    logic                  bne;
    logic [1:0]            pc_src;
    logic                  src_a;
    logic [1:0]            src_b;
    logic [ALU_CTRL_W-1:0] alu;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  sign;
    logic                  link;
  } ctl_t;

  function automatic logic funct_ok(input logic [5:0] f);
    case (f)
      F_SLL, F_SRL, F_SRA, F_ADD, F_SUB, F_AND, F_OR, F_SLT: return 1'b1;
      default:                                              return 1'b0;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] funct_alu(input logic [5:0] f);
    case (f)
      F_SLL:   return ALU_SLL;
      F_SRL:   return ALU_SRL;
      F_SRA:   return ALU_SRA;
      F_ADD:   return ALU_ADD;
      F_SUB:   return ALU_SUB;
      F_OR:    return ALU_OR;
      F_SLT:   return ALU_SLT;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [ALU_CTRL_W-1:0] imm_alu(input logic [5:0] op);
    case (op)
      OP_ADDI: return ALU_ADD;
      OP_SLTI: return ALU_SLT;
      OP_ORI:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic ctl_t moore(input state_e s, input logic [5:0] op,
                                 input logic [5:0] f);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.mem_req = 1'b1; c.fetch = 1'b1; c.src_b = 2'b01; c.alu = ALU_ADD; end
      S_DECODE: begin c.src_b = 2'b11; c.alu = ALU_ADD; c.sign = 1'b1; end
      S_MEMADR: begin c.src_a = 1'b1; c.src_b = 2'b10; c.alu = ALU_ADD; c.sign = 1'b1; end
      S_MEMRD:  begin c.mem_req = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWR:  begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.i_or_d = 1'b1; end
      S_MEMWB:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      S_EXEC: begin
        c.src_a = 1'b1;
        c.alu   = funct_alu(f);
        c.sign  = (f == F_SLL) || (f == F_SRL) || (f == F_SRA);
      end
      S_ALUWB:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      S_IMMEX: begin
        c.src_a = 1'b1;
        c.src_b = 2'b10;
        c.alu   = imm_alu(op);
        c.sign  = (op == OP_ADDI) || (op == OP_SLTI);
      end
      S_IMMWB:  c.reg_write = 1'b1;
      S_BRANCH: begin
        c.src_a  = 1'b1;
        c.alu    = ALU_SUB;
        c.pc_src = 2'b01;
        c.branch = 1'b1;
        c.bne    = (op == OP_BNE);
      end
      S_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
      S_JREG:   begin c.pc_src = 2'b11; c.pc_write = 1'b1; end
      S_JLINK:  begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.reg_write = 1'b1; c.link = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_e        state_q, state_d;
  ctl_t          ctl_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    op_q, op_d, funct_q, funct_d;
  logic          illegal_q, bus_err_q;
  logic          illegal_set, timeout, mem_wait;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    funct_d     = funct_q;
    illegal_set = 1'b0;
    mem_wait    = ctl_q.mem_req && !mem_ready_i;
    // Fires on the last permitted wait cycle; a same-cycle ready takes priority.
    timeout     = (MEM_TIMEOUT > 0) && mem_wait && (int'(cnt_q) >= MEM_TIMEOUT - 1);
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i)  state_d = S_DECODE;
        else if (timeout) state_d = S_ERROR;
      end
      S_DECODE: begin
        op_d    = op_i;
        funct_d = funct_i;
        case (op_i)
          OP_LW, OP_SW:                      state_d = S_MEMADR;
          OP_R:                              state_d = (funct_i == F_JR) ? S_JREG : S_EXEC;
          OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IMMEX;
          OP_J:                              state_d = S_JUMP;
          OP_JAL:                            state_d = S_JLINK;
          default: begin
            state_d     = S_ERROR;
            illegal_set = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready_i)  state_d = S_MEMWB;
        else if (timeout) state_d = S_ERROR;
      end
      S_MEMWR: begin
        if (mem_ready_i)  state_d = S_FETCH;
        else if (timeout) state_d = S_ERROR;
      end
      S_EXEC: begin
        if (funct_ok(funct_q)) begin
          state_d = S_ALUWB;
        end else begin
          state_d     = S_ERROR;
          illegal_set = 1'b1;
        end
      end
      S_IMMEX:  state_d = S_IMMWB;
      S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP, S_JREG, S_JLINK: state_d = S_FETCH;
      default:  state_d = S_ERROR;
    endcase

    if ((state_d != state_q) &&
        (state_d == S_FETCH || state_d == S_MEMRD || state_d == S_MEMWR))
      cnt_d = '0;
    else if (mem_wait && (cnt_q != {CW{1'b1}}))
      cnt_d = cnt_q + CW'(1);
    else
      cnt_d = cnt_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      ctl_q     <= moore(S_FETCH, 6'd0, 6'd0);
      cnt_q     <= '0;
      op_q      <= '0;
      funct_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctl_q     <= moore(state_d, op_d, funct_d);
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_q | illegal_set;
      bus_err_q <= bus_err_q | timeout;
    end
  end

  assign mem_req_o     = ctl_q.mem_req;
  assign mem_we_o      = ctl_q.mem_we;
  assign i_or_d_o      = ctl_q.i_or_d;
  assign ir_write_o    = ctl_q.fetch & mem_ready_i;
  assign pc_write_o    = ctl_q.pc_write | (ctl_q.fetch & mem_ready_i) |
                         (ctl_q.branch & (zero_i ^ ctl_q.bne));
  assign pc_src_o      = ctl_q.pc_src;
  assign alu_src_a_o   = ctl_q.src_a;
  assign alu_src_b_o   = ctl_q.src_b;
  assign alu_control_o = ctl_q.alu;
  assign reg_write_o   = ctl_q.reg_write;
  assign reg_dst_o     = ctl_q.reg_dst;
  assign mem_to_reg_o  = ctl_q.mem_to_reg;
  assign sign_o        = ctl_q.sign;
  assign link_o        = ctl_q.link;
  assign illegal_o     = illegal_q;
  assign bus_err_o     = bus_err_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed-vector bench for mc_control_fsm: instruction flows from a table, then
// hand-written timeout, illegal-instruction and asynchronous-reset sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic [5:0] op_i, funct_i;
  logic       zero_i, mem_ready_i;
  logic       mem_req_o, mem_we_o, i_or_d_o, ir_write_o, pc_write_o;
  logic [1:0] pc_src_o, alu_src_b_o;
  logic       alu_src_a_o;
  logic [3:0] alu_control_o;
  logic       reg_write_o, reg_dst_o, mem_to_reg_o, sign_o, link_o, illegal_o, bus_err_o;

  mc_control_fsm #(.MEM_TIMEOUT(4), .ALU_CTRL_W(4)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .op_i(op_i), .funct_i(funct_i), .zero_i(zero_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .i_or_d_o(i_or_d_o), .ir_write_o(ir_write_o), .pc_write_o(pc_write_o),
    .pc_src_o(pc_src_o), .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o),
    .alu_control_o(alu_control_o), .reg_write_o(reg_write_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .sign_o(sign_o), .link_o(link_o),
    .illegal_o(illegal_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  typedef enum int {
    T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWR, T_MEMWB, T_EXEC, T_ALUWB,
    T_IMMEX, T_IMMWB, T_BRANCH, T_JUMP, T_JREG, T_JLINK, T_ERR_IL, T_ERR_BE
  } t_st;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       a;
    logic [1:0] b;
    logic [3:0] alu;
    logic       reg_write, reg_dst, mem_to_reg, sign, link, illegal, bus_err;
  } out_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  localparam logic [5:0] XX = 6'h3f;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  // x = ready in FETCH, expected pc_write in BRANCH; alu/sg used by EXEC/IMMEX.
  function automatic out_t E(input t_st s, input logic x, input logic [3:0] alu, input logic sg);
    out_t o;
    o = '0;
    case (s)
      T_FETCH:  begin o.mem_req = 1; o.ir_write = x; o.pc_write = x; o.b = 2'b01; o.alu = 4'd2; end
      T_DECODE: begin o.b = 2'b11; o.alu = 4'd2; o.sign = 1; end
      T_MEMADR: begin o.a = 1; o.b = 2'b10; o.alu = 4'd2; o.sign = 1; end
      T_MEMRD:  begin o.mem_req = 1; o.i_or_d = 1; end
      T_MEMWR:  begin o.mem_req = 1; o.mem_we = 1; o.i_or_d = 1; end
      T_MEMWB:  begin o.reg_write = 1; o.mem_to_reg = 1; end
      T_EXEC:   begin o.a = 1; o.alu = alu; o.sign = sg; end
      T_ALUWB:  begin o.reg_write = 1; o.reg_dst = 1; end
      T_IMMEX:  begin o.a = 1; o.b = 2'b10; o.alu = alu; o.sign = sg; end
      T_IMMWB:  o.reg_write = 1;
      T_BRANCH: begin o.a = 1; o.alu = 4'd6; o.pc_src = 2'b01; o.pc_write = x; end
      T_JUMP:   begin o.pc_src = 2'b10; o.pc_write = 1; end
      T_JREG:   begin o.pc_src = 2'b11; o.pc_write = 1; end
      T_JLINK:  begin o.pc_src = 2'b10; o.pc_write = 1; o.reg_write = 1; o.link = 1; end
      T_ERR_IL: o.illegal = 1;
      T_ERR_BE: o.bus_err = 1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic out_t act();
    out_t o;
    o.mem_req = mem_req_o;     o.mem_we = mem_we_o;       o.i_or_d = i_or_d_o;
    o.ir_write = ir_write_o;   o.pc_write = pc_write_o;   o.pc_src = pc_src_o;
    o.a = alu_src_a_o;         o.b = alu_src_b_o;         o.alu = alu_control_o;
    o.reg_write = reg_write_o; o.reg_dst = reg_dst_o;     o.mem_to_reg = mem_to_reg_o;
    o.sign = sign_o;           o.link = link_o;           o.illegal = illegal_o;
    o.bus_err = bus_err_o;
    return o;
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = act();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic r, input out_t e);
    vec_t v;
    v.op = op; v.funct = fn; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  // Drive inputs just after a rising edge, compare on the falling edge.
  task automatic cyc(input logic [5:0] op, input logic [5:0] fn, input logic z,
                     input logic r, input bit chk, input out_t e, input string nm);
    op_i = op; funct_i = fn; zero_i = z; mem_ready_i = r;
    @(negedge clk);
    if (chk) check(nm, e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input string nm);
    mem_ready_i = 1'b0;
    rst_ni = 1'b0;
    #2;
    check(nm, E(T_FETCH, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic add_fetch();
    add(XX, XX, 0, 1, E(T_FETCH, 1, 0, 0));
  endtask

  logic [5:0] rt_f  [6] = '{6'h00, 6'h02, 6'h22, 6'h2a, 6'h24, 6'h25};
  logic [3:0] rt_a  [6] = '{4'd3, 4'd8, 4'd6, 4'd7, 4'd0, 4'd1};
  logic       rt_s  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [5:0] im_o  [4] = '{6'h08, 6'h0a, 6'h0c, 6'h0d};
  logic [3:0] im_a  [4] = '{4'd2, 4'd7, 4'd0, 4'd1};
  logic       im_s  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    rst_ni = 1'b0; op_i = '0; funct_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;

    // ADD with ready every cycle
    add_fetch();
    add(6'h00, 6'h20, 0, 1, E(T_DECODE, 0, 0, 0));
    add(6'h00, 6'h20, 0, 1, E(T_EXEC, 0, 4'd2, 0));
    add(XX, XX, 0, 1, E(T_ALUWB, 0, 0, 0));
    // LW, three wait cycles, opcode changes after decode are ignored
    add_fetch();
    add(6'h23, XX, 0, 0, E(T_DECODE, 0, 0, 0));
    add(6'h2b, XX, 0, 0, E(T_MEMADR, 0, 0, 0));
    for (int i = 0; i < 3; i++) add(XX, XX, 0, 0, E(T_MEMRD, 0, 0, 0));
    add(XX, XX, 0, 1, E(T_MEMRD, 0, 0, 0));
    add(XX, XX, 0, 0, E(T_MEMWB, 0, 0, 0));
    // SW
    add_fetch();
    add(6'h2b, XX, 0, 0, E(T_DECODE, 0, 0, 0));
    add(6'h23, XX, 0, 0, E(T_MEMADR, 0, 0, 0));
    add(XX, XX, 0, 1, E(T_MEMWR, 0, 0, 0));
    // BEQ/BNE
    add_fetch(); add(6'h04, XX, 0, 0, E(T_DECODE, 0, 0, 0)); add(XX, XX, 1, 0, E(T_BRANCH, 1, 0, 0));
    add_fetch(); add(6'h04, XX, 0, 0, E(T_DECODE, 0, 0, 0)); add(XX, XX, 0, 0, E(T_BRANCH, 0, 0, 0));
    add_fetch(); add(6'h05, XX, 0, 0, E(T_DECODE, 0, 0, 0)); add(XX, XX, 1, 0, E(T_BRANCH, 0, 0, 0));
    add_fetch(); add(6'h05, XX, 0, 0, E(T_DECODE, 0, 0, 0)); add(6'h04, XX, 0, 0, E(T_BRANCH, 1, 0, 0));
    // Immediate ALU ops
    for (int i = 0; i < 4; i++) begin
      add_fetch();
      add(im_o[i], XX, 0, 0, E(T_DECODE, 0, 0, 0));
      add(im_o[i], XX, 0, 0, E(T_IMMEX, 0, im_a[i], im_s[i]));
      add(XX, XX, 0, 0, E(T_IMMWB, 0, 0, 0));
    end
    // Remaining R-type functs, including SRA
    for (int i = 0; i < 6; i++) begin
      add_fetch();
      add(6'h00, rt_f[i], 0, 0, E(T_DECODE, 0, 0, 0));
      add(6'h00, rt_f[i], 0, 0, E(T_EXEC, 0, rt_a[i], rt_s[i]));
      add(XX, XX, 0, 0, E(T_ALUWB, 0, 0, 0));
    end
    add_fetch(); add(6'h00, 6'h03, 0, 0, E(T_DECODE, 0, 0, 0));
    add(6'h00, 6'h03, 0, 0, E(T_EXEC, 0, 4'd9, 1)); add(XX, XX, 0, 0, E(T_ALUWB, 0, 0, 0));
    // Jumps
    add_fetch(); add(6'h02, XX, 0, 0, E(T_DECODE, 0, 0, 0)); add(XX, XX, 0, 0, E(T_JUMP, 0, 0, 0));
    add_fetch(); add(6'h00, 6'h08, 0, 0, E(T_DECODE, 0, 0, 0)); add(XX, XX, 0, 0, E(T_JREG, 0, 0, 0));
    add_fetch(); add(6'h03, XX, 0, 0, E(T_DECODE, 0, 0, 0)); add(XX, XX, 0, 0, E(T_JLINK, 0, 0, 0));
    add(XX, XX, 0, 0, E(T_FETCH, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset", E(T_FETCH, 0, 0, 0));
    rst_ni = 1'b1;
    cyc(XX, XX, 0, 0, 1, E(T_FETCH, 0, 0, 0), "first_fetch");

    foreach (vecs[i])
      cyc(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].rdy, 1'b1, vecs[i].exp,
          $sformatf("vec%0d", i));

    // Fetch timeout after four wait cycles, error holds
    reset_dut("rst_timeout");
    for (int i = 0; i < 4; i++) cyc(XX, XX, 0, 0, 1, E(T_FETCH, 0, 0, 0), "to_wait");
    cyc(XX, XX, 0, 0, 1, E(T_ERR_BE, 0, 0, 0), "to_error");
    cyc(6'h00, 6'h20, 0, 1, 1, E(T_ERR_BE, 0, 0, 0), "to_hold");

    // Ready on the fourth wait cycle completes normally
    reset_dut("rst_noerr");
    for (int i = 0; i < 3; i++) cyc(XX, XX, 0, 0, 1, E(T_FETCH, 0, 0, 0), "ne_wait");
    cyc(XX, XX, 0, 1, 1, E(T_FETCH, 1, 0, 0), "ne_ready");
    cyc(6'h00, 6'h20, 0, 0, 1, E(T_DECODE, 0, 0, 0), "ne_decode");

    // Illegal opcode, then reset clears flags
    reset_dut("rst_il");
    cyc(XX, XX, 0, 1, 1, E(T_FETCH, 1, 0, 0), "il_fetch");
    cyc(6'h3f, 6'h20, 0, 0, 1, E(T_DECODE, 0, 0, 0), "il_decode");
    cyc(6'h00, 6'h20, 0, 1, 1, E(T_ERR_IL, 0, 0, 0), "il_error");
    cyc(6'h23, 6'h20, 1, 1, 1, E(T_ERR_IL, 0, 0, 0), "il_hold");
    reset_dut("il_reset");
    cyc(XX, XX, 0, 0, 1, E(T_FETCH, 0, 0, 0), "il_cleared");

    // Illegal funct in EXEC
    cyc(XX, XX, 0, 1, 1, E(T_FETCH, 1, 0, 0), "if_fetch");
    cyc(6'h00, 6'h3f, 0, 0, 1, E(T_DECODE, 0, 0, 0), "if_decode");
    cyc(6'h00, 6'h3f, 0, 0, 0, E(T_EXEC, 0, 0, 0), "if_exec");
    cyc(XX, XX, 0, 0, 1, E(T_ERR_IL, 0, 0, 0), "if_error");

    // Asynchronous reset in the middle of a store wait
    reset_dut("rst_sw");
    cyc(XX, XX, 0, 1, 1, E(T_FETCH, 1, 0, 0), "sw_fetch");
    cyc(6'h2b, XX, 0, 0, 1, E(T_DECODE, 0, 0, 0), "sw_decode");
    cyc(XX, XX, 0, 0, 1, E(T_MEMADR, 0, 0, 0), "sw_memadr");
    cyc(XX, XX, 0, 0, 1, E(T_MEMWR, 0, 0, 0), "sw_wait");
    tests++;
    if (mem_we_o !== 1'b1) begin
      fails++;
      $display("FAIL sw_we_before: got %b expected 1", mem_we_o);
    end
    rst_ni = 1'b0;
    #1;
    check("sw_async", E(T_FETCH, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    cyc(XX, XX, 0, 0, 1, E(T_FETCH, 0, 0, 0), "sw_refetch");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
